// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: collects byte-serial job headers for a miner and serialises its nonce results
// Ports: clk/rst_n clock and async active-low reset; rx_valid/rx_data/rx_ready job byte input;
// job_valid/job_data one-cycle job issue to the miner; miner_busy/miner_valid/miner_nonce miner status and results;
// tx_valid/tx_data/tx_ready result byte output (LSB first); drop_cnt saturating count of discarded results.
module miner_job_ctrl #(
  parameter int JOB_BYTES   = 76,
  parameter int NONCE_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   job_valid,
  output logic [8*JOB_BYTES-1:0] job_data,
  input  logic                   miner_busy,
  input  logic                   miner_valid,
  input  logic [31:0]            miner_nonce,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [7:0]             drop_cnt
);
  localparam int CW = $clog2(JOB_BYTES);
  typedef enum logic {COLLECT, ISSUE} state_t;
  state_t state, state_n;
  logic run, rx_acc, rx_last, issue;
  logic [CW-1:0] cnt;
  logic [8*JOB_BYTES-1:0] cbuf;
  logic full, tx_acc, tx_last, take;
  logic [1:0] idx;
  logic [31:0] nbuf;
  // run keeps rx_ready low while reset is held and rises on the first edge after release
  assign rx_ready = run && state == COLLECT;
  assign rx_acc   = rx_valid && rx_ready;
  assign rx_last  = rx_acc && cnt == CW'(JOB_BYTES - 1);
  always_comb begin
    issue   = state == ISSUE && !miner_busy;
    state_n = state == COLLECT ? (rx_last ? ISSUE : COLLECT) : (miner_busy ? ISSUE : COLLECT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run       <= 1'b0;
      cnt       <= '0;
      cbuf      <= '0;
      job_valid <= 1'b0;
      job_data  <= '0;
    end else begin
      run       <= 1'b1;
      job_valid <= issue;
      if (issue) job_data <= cbuf;
      if (rx_acc) begin
        cbuf[{cnt, 3'b000} +: 8] <= rx_data;
        cnt                      <= rx_last ? '0 : cnt + 1'b1;
      end
    end
  assign tx_valid = full;
  assign tx_data  = nbuf[{idx, 3'b000} +: 8];
  assign tx_acc   = full && tx_ready;
  assign tx_last  = tx_acc && idx == 2'(NONCE_BYTES - 1);
  // a new nonce may refill the buffer in the same cycle its last byte leaves, avoiding a bubble
  assign take     = miner_valid && (!full || tx_last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full     <= 1'b0;
      idx      <= '0;
      nbuf     <= '0;
      drop_cnt <= '0;
    end else begin
      if (take) begin
        nbuf <= miner_nonce;
        full <= 1'b1;
        idx  <= '0;
      end else if (tx_last) begin
        full <= 1'b0;
        idx  <= '0;
      end else if (tx_acc) idx <= idx + 1'b1;
      if (miner_valid && !take && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_miner_job_ctrl.sv
// tb_miner_job_ctrl: scoreboard bench for miner_job_ctrl with directed job and nonce vectors
module tb_miner_job_ctrl;
  localparam int JB = 76;
  logic clk = 0, rst_n = 0, rx_valid = 0, miner_busy = 0, miner_valid = 0, tx_ready = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] miner_nonce = 0;
  logic rx_ready, job_valid, tx_valid;
  logic [8*JB-1:0] job_data;
  logic [7:0] tx_data, drop_cnt;
  int vecs = 0, errs = 0;
  logic [8*JB-1:0] job_q[$];
  logic [7:0] tx_q[$];
  always #5 clk = ~clk;
  miner_job_ctrl #(.JOB_BYTES(JB), .NONCE_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .job_valid(job_valid), .job_data(job_data), .miner_busy(miner_busy), .miner_valid(miner_valid),
    .miner_nonce(miner_nonce), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .drop_cnt(drop_cnt)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic monitor();
    logic stall = 0;
    logic [7:0] held = 0;
    logic [8*JB-1:0] pj = '0;
    logic [8*JB-1:0] ej;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall) begin
          chk("tx_hold_valid", tx_valid, 1);
          chk("tx_hold_data", tx_data, held);
        end
        vecs++;
        if (job_valid) begin
          if (job_q.size() == 0) begin
            errs++;
            $display("FAIL job_unexpected: got job_valid=1 expected no job");
          end else begin
            ej = job_q.pop_front();
            if (job_data !== ej) begin
              errs++;
              $display("FAIL job_data: got %h expected %h", job_data, ej);
            end
          end
        end else if (job_data !== pj) begin
          errs++;
          $display("FAIL job_hold: got %h expected %h", job_data, pj);
        end
        if (tx_valid && tx_ready) begin
          vecs++;
          if (tx_q.size() == 0) begin
            errs++;
            $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
          end else begin
            eb = tx_q.pop_front();
            if (tx_data !== eb) begin
              errs++;
              $display("FAIL tx_data: got %h expected %h", tx_data, eb);
            end
          end
        end
      end
      stall = rst_n && tx_valid && !tx_ready;
      held  = tx_data;
      pj    = job_data;
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid = 1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      vecs++;
      errs++;
      $display("FAIL rx_timeout: got rx_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send_job(input logic [8*JB-1:0] j, input int first, input bit lat);
    for (int k = first; k < JB; k++) send(j[8*k +: 8]);
    rx_valid = 0;
    if (lat) begin
      @(negedge clk);
      chk("job_lat_t1", job_valid, 0);
      @(negedge clk);
      chk("job_lat_t2", job_valid, 1);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_nonce(input logic [31:0] n);
    for (int i = 0; i < 4; i++) tx_q.push_back(n[8*i +: 8]);
  endtask
  task automatic pulse(input logic [31:0] n);
    miner_nonce = n;
    miner_valid = 1;
    @(posedge clk);
    #1;
    miner_valid = 0;
  endtask
  initial begin
    logic [8*JB-1:0] j;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_job_valid", job_valid, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_job_data", 64'(job_data != '0), 0);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    chk("rx_ready_first_edge", rx_ready, 1);
    tx_ready = 1;
    for (int k = 0; k < JB; k++) j[8*k +: 8] = 8'(k);
    job_q.push_back(j);
    send_job(j, 0, 1);
    miner_busy = 1;
    for (int k = 0; k < JB; k++) j[8*k +: 8] = 8'(k * 3 + 1);
    job_q.push_back(j);
    send_job(j, 0, 0);
    rx_valid = 1;
    rx_data  = 8'hA0;
    repeat (8) begin
      @(negedge clk);
      chk("busy_rx_ready", rx_ready, 0);
      chk("busy_job_valid", job_valid, 0);
    end
    @(posedge clk);
    #1;
    miner_busy = 0;
    @(negedge clk);
    chk("unbusy_job_valid_t0", job_valid, 0);
    @(negedge clk);
    chk("unbusy_job_valid_t1", job_valid, 1);
    chk("unbusy_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < JB; k++) j[8*k +: 8] = k < 5 ? 8'(8'hA0 + k) : 8'(k ^ 8'h5A);
    job_q.push_back(j);
    send_job(j, 1, 1);
    push_nonce(32'hDEADBEEF);
    pulse(32'hDEADBEEF);
    repeat (30) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    tx_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("tx_q_empty_deadbeef", tx_q.size(), 0);
    tx_ready = 0;
    push_nonce(32'h01020304);
    pulse(32'h01020304);
    pulse(32'h55555555);
    pulse(32'h66666666);
    @(negedge clk);
    chk("drop_cnt_2", drop_cnt, 2);
    chk("retained_byte0", tx_data, 8'h04);
    @(posedge clk);
    #1;
    miner_valid = 1;
    repeat (300) @(posedge clk);
    #1;
    miner_valid = 0;
    @(negedge clk);
    chk("drop_cnt_sat", drop_cnt, 255);
    @(posedge clk);
    #1;
    tx_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("tx_q_empty_retained", tx_q.size(), 0);
    push_nonce(32'hCAFEF00D);
    push_nonce(32'h11223344);
    pulse(32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #1;
    pulse(32'h11223344);
    @(negedge clk);
    chk("no_bubble_tx_valid", tx_valid, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("tx_q_empty_back2back", tx_q.size(), 0);
    tx_ready = 0;
    for (int k = 0; k < 40; k++) send(8'(k + 100));
    rx_valid = 0;
    pulse(32'h99887766);
    @(negedge clk);
    chk("pre_rst_tx_valid", tx_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_job_valid", job_valid, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_job_data", 64'(job_data != '0), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    tx_ready = 1;
    for (int k = 0; k < JB; k++) j[8*k +: 8] = 8'(255 - k);
    job_q.push_back(j);
    send_job(j, 0, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("job_q_empty_end", job_q.size(), 0);
    chk("tx_q_empty_end", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
